// File: rtl/axilm_wr_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axilm_wr_arb
// Round-robin arbiter that shares a single AXI-Lite write master between
// NUM_REQ local requesters. One write is in flight at a time. The winning
// payload is latched onto the master's local port, a one-cycle m_ena issues it,
// and the master's completion pulse (m_done/m_bresp) is routed back to the
// owning requester. A watchdog completes hung writes with SLVERR.
// Zero-strobe writes are never sent to the master; they complete locally
// with OKAY.
//
// Ports
//   ACLK, ARESETn     clock (rising edge), asynchronous active-low reset
//   req_valid[i]      requester i has a write pending (held until req_ack[i])
//   req_wstb/addr/wdata  packed per-requester payload, slice i for requester i
//   req_ack[i]        one-cycle pulse: payload of requester i captured
//   req_done[i]       one-cycle pulse: write of requester i complete
//   req_bresp         response belonging to the latest req_done, held
//   m_ena             one-cycle issue pulse to the write master
//   m_wstb/addr/wdata latched payload, stable from issue to the next capture
//   m_done, m_bresp   master completion pulse and its response
//   busy              high whenever a write is being handled
//   grant_id          index of the current or most recent grantee
// -----------------------------------------------------------------------------
module axilm_wr_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256,
  localparam int STB_W      = DATA_W / 8,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*STB_W-1:0]  req_wstb,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [1:0]                req_bresp,
  output logic                      m_ena,
  output logic [STB_W-1:0]          m_wstb,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic                      m_done,
  input  logic [1:0]                m_bresp,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic [STB_W-1:0]   win_wstb;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;
  logic [WD_W-1:0]    wdog;
  logic               wd_expire;
  logic               local_ack;
  logic [1:0]         bresp_q;
  logic [NUM_REQ-1:0] grant_oh;

  // Winner: first pending requester after last_grant, wrapping around.
  always_comb begin
    logic [ID_W-1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign win_wstb  = req_wstb [win_id*STB_W  +: STB_W];
  assign win_addr  = req_addr [win_id*ADDR_W +: ADDR_W];
  assign win_wdata = req_wdata[win_id*DATA_W +: DATA_W];

  // The watchdog holds the number of cycles elapsed since the issue cycle,
  // so the forced completion lands TIMEOUT_CYC cycles after m_ena.
  generate
    if (TIMEOUT_CYC == 0) begin : g_no_wdog
      assign wd_expire = 1'b0;
    end else begin : g_wdog
      assign wd_expire = (wdog >= WD_W'(TIMEOUT_CYC - 1));
    end
  endgenerate

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and state-decoded strobes
  always_comb begin
    state_nxt = state;
    m_ena     = 1'b0;
    busy      = 1'b1;
    req_ack   = '0;
    req_done  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (win_found) state_nxt = (win_wstb == '0) ? RESP : ISSUE;
      end
      ISSUE: begin
        m_ena     = 1'b1;
        req_ack   = grant_oh;
        state_nxt = WAIT;
      end
      WAIT: begin
        // m_done has priority over a coinciding watchdog expiry
        if (m_done || wd_expire) state_nxt = RESP;
      end
      RESP: begin
        // zero-strobe writes skipped ISSUE, so their ack is given here
        if (local_ack) req_ack = grant_oh;
        req_done  = grant_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_oh  = NUM_REQ'(1) << grant_id;
  assign req_bresp = bresp_q;

  // Payload capture, response, watchdog and round-robin pointer
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      m_wstb     <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      bresp_q    <= 2'b00;
      local_ack  <= 1'b0;
      wdog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_id  <= win_id;
            m_wstb    <= win_wstb;
            m_addr    <= win_addr;
            m_wdata   <= win_wdata;
            local_ack <= (win_wstb == '0);
            if (win_wstb == '0) bresp_q <= 2'b00;
          end
        end
        ISSUE: wdog <= WD_W'(1);
        WAIT: begin
          wdog <= wdog + 1'b1;
          if (m_done)         bresp_q <= m_bresp;
          else if (wd_expire) bresp_q <= 2'b10;
        end
        RESP: begin
          last_grant <= grant_id;
          local_ack  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axilm_wr_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_axilm_wr_arb
// Self-checking bench for axilm_wr_arb (NUM_REQ=4, TIMEOUT_CYC=16).
// A transaction-level reference model predicts, every cycle, which requester
// is granted, when ack/done/m_ena/busy pulse and which response is returned,
// from the round-robin rule and completion timing arithmetic. Directed
// scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_axilm_wr_arb;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int IW = 2;
  localparam int TO = 16;

  logic             ACLK = 1'b0;
  logic             ARESETn;
  logic [NR-1:0]    req_valid;
  logic [NR*SW-1:0] req_wstb;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_ack;
  logic [NR-1:0]    req_done;
  logic [1:0]       req_bresp;
  logic             m_ena;
  logic [SW-1:0]    m_wstb;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic             m_done;
  logic [1:0]       m_bresp;
  logic             busy;
  logic [IW-1:0]    grant_id;

  axilm_wr_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_wstb(req_wstb), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_done(req_done), .req_bresp(req_bresp),
    .m_ena(m_ena), .m_wstb(m_wstb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_done(m_done), .m_bresp(m_bresp), .busy(busy), .grant_id(grant_id)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(logic [NR-1:0] v, int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  // ---------------- reference model / monitor (negedge) ----------------
  logic [NR-1:0] s_ack = '0, s_done = '0;
  logic          s_ena = 1'b0, s_busy = 1'b0;
  logic [NR-1:0] prev_valid = '0;
  logic [AW-1:0] prev_addr [NR];
  logic [DW-1:0] prev_data [NR];
  logic [SW-1:0] prev_stb  [NR];
  bit            prev_free = 1'b0;
  bit            tx_act = 1'b0, tx_zero, tx_res;
  int            tx_id, tx_issue, tx_dcyc;
  logic [1:0]    tx_bresp;
  int            last_g = NR - 1;
  int            ack_log[$];
  int            ena_cnt = 0, ack_cnt = 0, done_cnt = 0;
  int            last_ena_cyc = 0, last_done_cyc = 0;
  logic [1:0]    last_bresp = 2'b00;
  logic [NR-1:0] eack, edone;
  logic          eena, ebusy;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      chk("rst_ctl", {req_ack, req_done, m_ena, busy, grant_id, req_bresp, m_wstb}, '0);
      chk("rst_pay", {m_addr, m_wdata}, '0);
      tx_act = 1'b0; last_g = NR - 1; prev_free = 1'b0;
      s_ack = '0; s_done = '0; s_ena = 1'b0; s_busy = 1'b0;
    end else begin
      if (prev_free && prev_valid != '0) begin
        tx_id    = rr_pick(prev_valid, last_g);
        tx_act   = 1'b1;
        tx_zero  = (prev_stb[tx_id] == '0);
        tx_issue = cyc;
        tx_res   = tx_zero;
        tx_dcyc  = cyc;
        tx_bresp = 2'b00;
        ack_log.push_back(tx_id);
        chk("grant_id", grant_id, tx_id);
        chk("m_addr",   m_addr,   prev_addr[tx_id]);
        chk("m_wdata",  m_wdata,  prev_data[tx_id]);
        chk("m_wstb",   m_wstb,   prev_stb[tx_id]);
      end
      eack = '0; edone = '0; eena = 1'b0; ebusy = tx_act;
      if (tx_act) begin
        if (cyc == tx_issue) begin
          eack[tx_id] = 1'b1;
          eena = !tx_zero;
        end
        if (tx_res && cyc == tx_dcyc) begin
          edone[tx_id] = 1'b1;
          chk("bresp", req_bresp, tx_bresp);
        end else if (!tx_res && cyc > tx_issue) begin
          if (m_done && cyc <= tx_issue + TO - 1) begin
            tx_res = 1'b1; tx_dcyc = cyc + 1; tx_bresp = m_bresp;
          end else if (cyc == tx_issue + TO - 1) begin
            tx_res = 1'b1; tx_dcyc = cyc + 1; tx_bresp = 2'b10;
          end
        end
      end
      chk("ctl{ack,done,ena,busy}", {req_ack, req_done, m_ena, busy}, {eack, edone, eena, ebusy});
      if (edone != '0) begin last_g = tx_id; tx_act = 1'b0; end
      if (m_ena) begin ena_cnt++; last_ena_cyc = cyc; end
      if (req_ack != '0) ack_cnt++;
      if (req_done != '0) begin done_cnt++; last_done_cyc = cyc; last_bresp = req_bresp; end
      s_ack = req_ack; s_done = req_done; s_ena = m_ena; s_busy = busy;
      prev_free = !ebusy;
    end
    prev_valid = req_valid;
    for (int i = 0; i < NR; i++) begin
      prev_addr[i] = req_addr [i*AW +: AW];
      prev_data[i] = req_wdata[i*DW +: DW];
      prev_stb[i]  = req_wstb [i*SW +: SW];
    end
  end

  // ---------------- stimulus ----------------
  logic [NR-1:0] en_mask = '0;
  logic [NR-1:0] wdone = '0;
  int            rate = 0;
  int            mlat_fix = 0;
  int            mbresp_fix = -1;
  bit            lat_long = 1'b0, spurious = 1'b0;
  bit            md_pend = 1'b0;
  int            md_at = 0;
  logic [1:0]    md_bresp = 2'b00;

  task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    req_addr [i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_wstb [i*SW +: SW] = s;
    req_valid[i] = 1'b1;
  endtask

  task automatic step();
    int lat;
    @(posedge ACLK); #1;
    for (int i = 0; i < NR; i++) begin
      if (s_ack[i]) begin req_valid[i] = 1'b0; wdone[i] = 1'b1; end
      if (s_done[i]) wdone[i] = 1'b0;
      if (!req_valid[i] && !wdone[i] && en_mask[i] && ARESETn && ($urandom_range(99) < rate))
        set_req(i, $urandom, $urandom,
                ($urandom_range(7) == 0) ? 4'h0 : 4'($urandom_range(15, 1)));
    end
    m_done  = 1'b0;
    m_bresp = 2'($urandom_range(3));
    if (s_ena) begin
      if (mlat_fix > 0) lat = mlat_fix;
      else if (lat_long && $urandom_range(9) == 0) lat = $urandom_range(18, 13);
      else lat = $urandom_range(5, 1);
      md_at    = cyc - 1 + lat;
      md_pend  = 1'b1;
      md_bresp = (mbresp_fix >= 0) ? 2'(mbresp_fix) : 2'($urandom_range(3));
    end
    if (md_pend && cyc == md_at) begin
      m_done = 1'b1; m_bresp = md_bresp; md_pend = 1'b0;
    end else if (!md_pend && spurious && $urandom_range(31) == 0) begin
      m_done = 1'b1;
    end
  endtask

  task automatic run_until_idle(int bound);
    bit ok = 1'b0;
    for (int n = 1; n <= bound; n++) begin
      step();
      if (n >= 2 && !s_busy && req_valid == '0 && wdone == '0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_bound", 1, 0);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    req_valid = '0; wdone = '0; md_pend = 1'b0; m_done = 1'b0;
    repeat (3) step();
    ARESETn = 1'b1;
  endtask

  initial begin
    int a0, d0, e0;
    bit seen;
    ARESETn = 1'b0;
    req_valid = '0; req_wstb = '0; req_addr = '0; req_wdata = '0;
    m_done = 1'b0; m_bresp = 2'b00;
    do_reset();

    // 1: single write from requester 0, master answers 3 cycles after m_ena
    mlat_fix = 3; mbresp_fix = 0; ack_log.delete(); e0 = ena_cnt;
    set_req(0, 32'h100, 32'hA5A5A5A5, 4'hF);
    run_until_idle(40);
    chk("t1_nacks", ack_log.size(), 1);
    chk("t1_ena_cnt", ena_cnt - e0, 1);
    chk("t1_lat", last_done_cyc - last_ena_cyc, 4);
    chk("t1_bresp", last_bresp, 0);

    // 2: all requesters continuously valid -> strict rotation from 0
    do_reset();
    ack_log.delete(); a0 = ack_cnt; d0 = done_cnt;
    mlat_fix = 0; mbresp_fix = -1; en_mask = '1; rate = 100;
    for (int n = 0; n < 300 && ack_log.size() < 8; n++) step();
    en_mask = '0;
    run_until_idle(100);
    chk("t2_nacks_ge8", ack_log.size() >= 8, 1);
    for (int k = 0; k < 8; k++)
      chk("t2_order", (k < ack_log.size()) ? ack_log[k] : -1, k % NR);
    chk("t2_done_per_txn", done_cnt - d0, ack_cnt - a0);

    // 3: zero-strobe write completes locally
    ack_log.delete(); e0 = ena_cnt;
    set_req(2, $urandom, $urandom, 4'h0);
    run_until_idle(20);
    chk("t3_nacks", ack_log.size(), 1);
    chk("t3_id", (ack_log.size() > 0) ? ack_log[0] : -1, 2);
    chk("t3_no_ena", ena_cnt - e0, 0);
    chk("t3_bresp", last_bresp, 0);

    // 4: master never answers in time -> SLVERR, late m_done ignored
    mlat_fix = TO + 1; mbresp_fix = 1;
    set_req(1, $urandom, $urandom, 4'h3);
    run_until_idle(60);
    chk("t4_bresp", last_bresp, 2'b10);
    chk("t4_lat", last_done_cyc - last_ena_cyc, TO);
    mlat_fix = 2; mbresp_fix = 1;
    set_req(3, $urandom, $urandom, 4'h8);
    run_until_idle(30);
    chk("t4_next_bresp", last_bresp, 2'b01);
    chk("t4_next_lat", last_done_cyc - last_ena_cyc, 3);

    // 5: m_done in the same cycle as the watchdog expiry wins
    mlat_fix = TO - 1; mbresp_fix = 3;
    set_req(0, $urandom, $urandom, 4'hF);
    run_until_idle(60);
    chk("t5_bresp", last_bresp, 2'b11);
    chk("t5_lat", last_done_cyc - last_ena_cyc, TO);

    // 6: reset while waiting on the master
    mlat_fix = 1000; mbresp_fix = 0;
    set_req(2, $urandom, $urandom, 4'hF);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin step(); seen = s_ena; end
    chk("t6_issue_seen", seen, 1);
    repeat (3) step();
    #2 ARESETn = 1'b0;
    #1 chk("t6_async_out", {req_ack, req_done, m_ena, busy, grant_id, req_bresp, m_wstb, m_addr[7:0]}, '0);
    req_valid = '0; wdone = '0; md_pend = 1'b0; m_done = 1'b0;
    repeat (2) step();
    ARESETn = 1'b1;
    ack_log.delete(); d0 = done_cnt;
    mlat_fix = 2; mbresp_fix = 0;
    set_req(3, $urandom, $urandom, 4'h1);
    set_req(1, $urandom, $urandom, 4'h2);
    set_req(2, $urandom, $urandom, 4'h4);
    set_req(0, $urandom, $urandom, 4'hF);
    run_until_idle(80);
    chk("t6_first", (ack_log.size() > 0) ? ack_log[0] : -1, 0);
    chk("t6_dones", done_cnt - d0, 4);

    // randomized traffic, including slow masters and stray completions
    a0 = ack_cnt; d0 = done_cnt;
    mlat_fix = 0; mbresp_fix = -1; lat_long = 1'b1; spurious = 1'b1;
    en_mask = '1; rate = 25;
    repeat (3000) step();
    en_mask = '0; spurious = 1'b0;
    run_until_idle(200);
    chk("rand_done_per_txn", done_cnt - d0, ack_cnt - a0);
    chk("rand_activity", (ack_cnt - a0) > 100, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
